// File: rtl/score_bcd_counter.sv
// score_bcd_counter
//   Decimal (BCD) score counter driven by an asynchronous score event line.
//   Each synchronised rising edge of scoreToggle adds addAmount (clamped to 9)
//   to the score. The carry ripples through all digits in a single cycle.
//   A high-score register follows the score one cycle later.
//
// Ports
//   clk          in   rising-edge system clock
//   resetn       in   asynchronous active-low reset
//   scoreToggle  in   asynchronous score event, one add per rising edge
//   addAmount    in   [3:0] BCD addend, values above 9 are treated as 9
//   clearScore   in   synchronous clear of the score (wins over an event)
//   scoreBcd     out  [4*DIGITS-1:0] current score, digit 0 in bits [3:0]
//   highScoreBcd out  [4*DIGITS-1:0] highest score seen since reset
//   newHigh      out  one-cycle pulse when highScoreBcd is updated
//   overflow     out  sticky flag, set when an add carried out of the top digit
//   eventAck     out  one-cycle pulse, registered with the applied score update
module score_bcd_counter #(
  parameter int DIGITS      = 4,
  parameter int SATURATE    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  scoreToggle,
  input  logic [3:0]            addAmount,
  input  logic                  clearScore,
  output logic [4*DIGITS-1:0]   scoreBcd,
  output logic [4*DIGITS-1:0]   highScoreBcd,
  output logic                  newHigh,
  output logic                  overflow,
  output logic                  eventAck
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  // valid_q marks which synchroniser stages (plus the edge history bit) hold
  // samples taken after reset release. A detect requires the edge history to
  // be a real sample. A level still high at release therefore never counts as
  // an edge.
  logic [SYNC_STAGES:0]   valid_q, valid_d;
  logic                   prev_q, prev_d;
  logic [W-1:0]           score_q, score_d;
  logic [W-1:0]           high_q, high_d;
  logic                   new_high_q, new_high_d;
  logic                   ovf_q, ovf_d;
  logic                   ack_q, ack_d;

  logic                   detect_s;
  logic [3:0]             amt_s;
  logic [W-1:0]           sum_s;
  logic                   carry_s;

  // Decimal add of a single digit value to digit 0. The carry ripples through
  // every digit. Bit W of the result is the carry out of the top digit.
  function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input logic [3:0] amt);
    logic [W:0] r;
    logic [4:0] c;
    logic [4:0] s;
    logic [4:0] t;
    r = '0;
    c = {1'b0, amt};
    for (int i = 0; i < DIGITS; i++) begin
      s = {1'b0, a[4*i +: 4]} + c;
      t = s - 5'd10;
      if (s > 5'd9) begin
        r[4*i +: 4] = t[3:0];
        c = 5'd1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c = 5'd0;
      end
    end
    r[W] = c[0];
    return r;
  endfunction

  // Synchroniser, validity tracking and edge detection
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], scoreToggle};
    valid_d  = {valid_q[SYNC_STAGES-1:0], 1'b1};
    prev_d   = sync_q[SYNC_STAGES-1];
    detect_s = valid_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // Score, overflow, acknowledge and high-score next-state logic
  always_comb begin
    amt_s            = (addAmount > 4'd9) ? 4'd9 : addAmount;
    {carry_s, sum_s} = bcd_add(score_q, amt_s);
    score_d          = score_q;
    ovf_d            = ovf_q;
    ack_d            = 1'b0;
    high_d           = high_q;
    new_high_d       = 1'b0;

    if (clearScore) begin
      score_d = '0;                 // the event on this cycle is dropped
    end else if (detect_s) begin
      ack_d = 1'b1;
      if (carry_s) begin
        ovf_d = 1'b1;
        if (SATURATE != 0) begin
          score_d = ALL_NINES;
        end else begin
          score_d = sum_s;
        end
      end else begin
        score_d = sum_s;
      end
    end else begin
      score_d = score_q;
    end

    // Valid BCD orders the same as plain binary, so an unsigned compare works.
    if (score_q > high_q) begin
      high_d     = score_q;
      new_high_d = 1'b1;
    end else begin
      high_d     = high_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q     <= '0;
      valid_q    <= '0;
      prev_q     <= 1'b0;
      score_q    <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
      ovf_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      valid_q    <= valid_d;
      prev_q     <= prev_d;
      score_q    <= score_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      ovf_q      <= ovf_d;
      ack_q      <= ack_d;
    end
  end

  assign scoreBcd     = score_q;
  assign highScoreBcd = high_q;
  assign newHigh      = new_high_q;
  assign overflow     = ovf_q;
  assign eventAck     = ack_q;

endmodule

// File: tb/tb_score_bcd_counter.sv
module tb_score_bcd_counter;

  localparam int S    = 2;
  localparam int MAXV = 9999;

  logic        clk = 1'b0;
  logic        resetn;
  logic        scoreToggle;
  logic [3:0]  addAmount;
  logic        clearScore;
  logic [15:0] score_v[2];
  logic [15:0] high_v[2];
  logic        nh_v[2];
  logic        ovf_v[2];
  logic        ack_v[2];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain integer scores. Index 0 saturates, index 1 wraps.
  int ms[2];
  int mh[2];
  bit mov[2];
  bit mnh[2];

  always #5 clk = ~clk;

  score_bcd_counter #(.DIGITS(4), .SATURATE(1), .SYNC_STAGES(S)) u_sat (
    .clk(clk), .resetn(resetn), .scoreToggle(scoreToggle), .addAmount(addAmount),
    .clearScore(clearScore), .scoreBcd(score_v[0]), .highScoreBcd(high_v[0]),
    .newHigh(nh_v[0]), .overflow(ovf_v[0]), .eventAck(ack_v[0]));

  score_bcd_counter #(.DIGITS(4), .SATURATE(0), .SYNC_STAGES(S)) u_wrap (
    .clk(clk), .resetn(resetn), .scoreToggle(scoreToggle), .addAmount(addAmount),
    .clearScore(clearScore), .scoreBcd(score_v[1]), .highScoreBcd(high_v[1]),
    .newHigh(nh_v[1]), .overflow(ovf_v[1]), .eventAck(ack_v[1]));

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    int d;
    x = v;
    for (int i = 0; i < 4; i++) begin
      d = x % 10;
      r[4*i +: 4] = d[3:0];
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      ms[j] = 0; mh[j] = 0; mov[j] = 1'b0; mnh[j] = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int j = 0; j < 2; j++) begin
      chk({tag, "_score"}, {16'd0, score_v[j]}, 32'd0);
      chk({tag, "_high"},  {16'd0, high_v[j]},  32'd0);
      chk({tag, "_ovf"},   {31'd0, ovf_v[j]},   32'd0);
      chk({tag, "_nh"},    {31'd0, nh_v[j]},    32'd0);
      chk({tag, "_ack"},   {31'd0, ack_v[j]},   32'd0);
    end
  endtask

  // One scoreToggle edge with addend amt; if clr, clearScore is raised on the detect cycle.
  task automatic ev(input logic [3:0] amt, input bit clr);
    int a;
    int sum;
    @(negedge clk);
    addAmount   = amt;
    scoreToggle = 1'b1;
    repeat (S) @(posedge clk);
    @(negedge clk);
    chk("ack_early", {31'd0, ack_v[0]}, 32'd0);
    if (clr) clearScore = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clearScore = 1'b0;
    a = (amt > 4'd9) ? 9 : int'(amt);
    for (int j = 0; j < 2; j++) begin
      if (clr) begin
        ms[j] = 0;
      end else begin
        sum = ms[j] + a;
        if (sum > MAXV) begin
          mov[j] = 1'b1;
          ms[j]  = (j == 0) ? MAXV : sum - (MAXV + 1);
        end else begin
          ms[j] = sum;
        end
      end
      chk(j == 0 ? "ack_sat" : "ack_wrap", {31'd0, ack_v[j]}, {31'd0, !clr});
      chk(j == 0 ? "score_sat" : "score_wrap", {16'd0, score_v[j]}, {16'd0, to_bcd(ms[j])});
      chk(j == 0 ? "ovf_sat" : "ovf_wrap", {31'd0, ovf_v[j]}, {31'd0, mov[j]});
      mnh[j] = (ms[j] > mh[j]);
      if (mnh[j]) mh[j] = ms[j];
    end
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      chk(j == 0 ? "ack_once_sat" : "ack_once_wrap", {31'd0, ack_v[j]}, 32'd0);
      chk(j == 0 ? "newhigh_sat" : "newhigh_wrap", {31'd0, nh_v[j]}, {31'd0, mnh[j]});
      chk(j == 0 ? "high_sat" : "high_wrap", {16'd0, high_v[j]}, {16'd0, to_bcd(mh[j])});
    end
    scoreToggle = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_only();
    @(negedge clk);
    clearScore = 1'b1;
    @(negedge clk);
    clearScore = 1'b0;
    ms[0] = 0; ms[1] = 0;
    chk("clear_score", {16'd0, score_v[0]}, 32'd0);
    @(negedge clk);
    chk("clear_newhigh", {31'd0, nh_v[0]}, 32'd0);
    chk("clear_high", {16'd0, high_v[0]}, {16'd0, to_bcd(mh[0])});
  endtask

  initial begin
    resetn = 1'b0; scoreToggle = 1'b0; addAmount = 4'd0; clearScore = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // Ten unit events
    for (int i = 0; i < 10; i++) ev(4'd1, 1'b0);
    chk("ten_events", {16'd0, score_v[0]}, 32'h0010);

    // Build 42, then clear and event on the same cycle
    clear_only();
    for (int i = 0; i < 4; i++) ev(4'd9, 1'b0);
    ev(4'd6, 1'b0);
    chk("score_42", {16'd0, score_v[0]}, 32'h0042);
    ev(4'd3, 1'b1);
    chk("clr_wins_score", {16'd0, score_v[0]}, 32'h0000);
    chk("clr_keeps_high", {16'd0, high_v[0]}, 32'h0042);

    // Addend above 9 clamps to 9
    ev(4'hC, 1'b0);
    chk("clamp_c", {16'd0, score_v[0]}, 32'h0009);

    // Zero addend still acknowledged
    ev(4'd0, 1'b0);

    // Ripple 0999 + 5
    for (int i = 0; i < 110; i++) ev(4'd9, 1'b0);
    chk("score_0999", {16'd0, score_v[0]}, 32'h0999);
    ev(4'd5, 1'b0);
    chk("ripple_1004", {16'd0, score_v[0]}, 32'h1004);
    chk("high_1004", {16'd0, high_v[0]}, 32'h1004);

    // Up to 9995, then overflow in both variants
    for (int i = 0; i < 999; i++) ev(4'd9, 1'b0);
    chk("score_9995", {16'd0, score_v[1]}, 32'h9995);
    ev(4'd7, 1'b0);
    chk("sat_9999", {16'd0, score_v[0]}, 32'h9999);
    chk("wrap_0002", {16'd0, score_v[1]}, 32'h0002);
    chk("sat_ovf", {31'd0, ovf_v[0]}, 32'd1);
    chk("wrap_ovf", {31'd0, ovf_v[1]}, 32'd1);
    ev(4'd0, 1'b0);
    ev(4'd4, 1'b0);

    // Randomised events and clears against the model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) clear_only();
      else ev(4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
    end

    // Reset during a pending event with scoreToggle held high
    @(negedge clk);
    addAmount = 4'd1;
    scoreToggle = 1'b1;
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 check_zero("midreset");
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("held_high_ack", {31'd0, ack_v[0] | ack_v[1]}, 32'd0);
      chk("held_high_score", {16'd0, score_v[0]}, 32'd0);
    end
    scoreToggle = 1'b0;
    repeat (4) @(negedge clk);
    ev(4'd1, 1'b0);
    chk("after_reset_event", {16'd0, score_v[0]}, 32'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
